srl_delay_line: RTL and testbench

//  - Parametrised multi-bit delay line with a per-word valid flag and a depth selectable at run time.
//  - Stall support via ce; flush is driven by reconfiguration.
//  - Successor to the single-bit fixed-depth SRL.
//  - Aligns side-band data and valid strobes against compute pipelines whose latency varies by layer mode.

---
 rtl/srl_pkg.sv | 7 +
 rtl/srl_tap_mux.sv | 25 ++
 rtl/srl_delay_line.sv | 61 ++++++
 tb/tb_srl_delay_line.sv | 125 ++++++++++++
 4 files changed

// File: rtl/srl_pkg.sv
// srl_pkg: shared sizing helpers and limits for the selectable-depth delay line
package srl_pkg;
  localparam int SRL_DEPTH_MAX_SUPPORTED = 256;
  function automatic int srl_dw(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
endpackage

// File: rtl/srl_tap_mux.sv
// srl_tap_mux: selects stage[depth-1], or bypasses the input when depth is 0
module srl_tap_mux import srl_pkg::*; #(
  parameter int C_WIDTH = 16,
  parameter int C_MAX_DEPTH = 16,
  localparam int DW = srl_dw(C_MAX_DEPTH)
) (
  input  logic [DW-1:0]                         depth,
  input  logic [C_MAX_DEPTH-1:0]                stage_valid,
  input  logic [C_MAX_DEPTH-1:0][C_WIDTH-1:0]   stage_data,
  input  logic                                  valid_in,
  input  logic [C_WIDTH-1:0]                    data_in,
  output logic                                  valid_out,
  output logic [C_WIDTH-1:0]                    data_out
);
  always_comb begin
    valid_out = valid_in;
    data_out = data_in;
    for (int i = 0; i < C_MAX_DEPTH; i++) begin
      if (depth == DW'(i + 1)) begin
        valid_out = stage_valid[i];
        data_out = stage_data[i];
      end
    end
  end
endmodule

// File: rtl/srl_delay_line.sv
// srl_delay_line: multi-bit delay line with valid tracking and run-time selectable depth
module srl_delay_line import srl_pkg::*; #(
  parameter int C_WIDTH = 16,
  parameter int C_MAX_DEPTH = 16,
  parameter int C_DEFAULT_DEPTH = 4,
  localparam int DW = srl_dw(C_MAX_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               cfg_load,
  input  logic [DW-1:0]      delay_sel,
  input  logic               valid_in,
  input  logic [C_WIDTH-1:0] data_in,
  output logic               valid_out,
  output logic [C_WIDTH-1:0] data_out,
  output logic [DW-1:0]      depth_q,
  output logic [DW-1:0]      in_flight,
  output logic               cfg_err
);
  if (C_DEFAULT_DEPTH > C_MAX_DEPTH) begin : g_bad_default
    $error("C_DEFAULT_DEPTH exceeds C_MAX_DEPTH");
  end
  if (C_MAX_DEPTH > SRL_DEPTH_MAX_SUPPORTED) begin : g_bad_max
    $error("C_MAX_DEPTH exceeds SRL_DEPTH_MAX_SUPPORTED");
  end
  logic [C_MAX_DEPTH-1:0]              stage_valid;
  logic [C_MAX_DEPTH-1:0][C_WIDTH-1:0] stage_data;
  logic                                over;
  assign over = delay_sel > DW'(C_MAX_DEPTH);
  srl_tap_mux #(.C_WIDTH(C_WIDTH), .C_MAX_DEPTH(C_MAX_DEPTH)) u_tap (
    .depth(depth_q),
    .stage_valid(stage_valid),
    .stage_data(stage_data),
    .valid_in(valid_in),
    .data_in(data_in),
    .valid_out(valid_out),
    .data_out(data_out)
  );
  // Reconfiguration flushes only valid bits; stale data behind them is never observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= DW'(C_DEFAULT_DEPTH);
      stage_valid <= '0;
      stage_data <= '0;
      in_flight <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && over;
      if (cfg_load) begin
        depth_q <= over ? DW'(C_MAX_DEPTH) : delay_sel;
        stage_valid <= '0;
        in_flight <= '0;
      end else if (ce) begin
        stage_valid <= C_MAX_DEPTH'({stage_valid, valid_in});
        stage_data <= (C_MAX_DEPTH * C_WIDTH)'({stage_data, data_in});
        in_flight <= in_flight + DW'(valid_in & ~valid_out) - DW'(valid_out & ~valid_in);
      end
    end
  end
endmodule

// File: tb/tb_srl_delay_line.sv
// tb_srl_delay_line: table-driven plus hand-written corner sequences for srl_delay_line
module tb_srl_delay_line;
  localparam int DW = 5;
  typedef struct {
    logic rst, ce, ld;
    logic [DW-1:0] ds;
    logic vi;
    logic [15:0] di;
    logic ev;
    logic [15:0] ed;
    logic [DW-1:0] eq, ef;
    logic ee;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b0, cfg_load = 1'b0, valid_in = 1'b0;
  logic [DW-1:0] delay_sel = '0;
  logic [15:0] data_in = '0;
  logic valid_out, cfg_err;
  logic [15:0] data_out;
  logic [DW-1:0] depth_q, in_flight;
  int n_cmp = 0, n_err = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  srl_delay_line #(.C_WIDTH(16), .C_MAX_DEPTH(16), .C_DEFAULT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .cfg_load(cfg_load), .delay_sel(delay_sel),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
    .depth_q(depth_q), .in_flight(in_flight), .cfg_err(cfg_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic c, input logic l, input logic [DW-1:0] s,
                     input logic v, input logic [15:0] d);
    rst = r; ce = c; cfg_load = l; delay_sel = s; valid_in = v; data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, input logic c, input logic l, input logic [DW-1:0] s,
                     input logic v, input logic [15:0] d, input logic ev, input logic [15:0] ed,
                     input logic [DW-1:0] eq, input logic [DW-1:0] ef, input logic ee);
    vec_t t;
    t.rst = r; t.ce = c; t.ld = l; t.ds = s; t.vi = v; t.di = d;
    t.ev = ev; t.ed = ed; t.eq = eq; t.ef = ef; t.ee = ee;
    vecs.push_back(t);
  endtask
  initial begin
    int lat;
    // Reset then depth-4 stream of words 1..10
    add(1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    for (int k = 1; k <= 10; k++)
      add(0, 1, 0, 0, 1, 16'(k), k >= 4, k >= 4 ? 16'(k - 3) : 16'h0, 4, k >= 4 ? 5'd4 : 5'(k), 0);
    // Stall for 3 cycles: everything frozen, junk input ignored
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 16'hDEAD, 1, 16'd7, 4, 4, 0);
    add(0, 1, 0, 0, 1, 16'd11, 1, 16'd8, 4, 4, 0);
    add(0, 1, 0, 0, 1, 16'd12, 1, 16'd9, 4, 4, 0);
    // Drain
    add(0, 1, 0, 0, 0, 0, 1, 16'd10, 4, 3, 0);
    add(0, 1, 0, 0, 0, 0, 1, 16'd11, 4, 2, 0);
    add(0, 1, 0, 0, 0, 0, 1, 16'd12, 4, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'd0, 4, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'd0, 4, 0, 0);
    // Depth 0 bypass
    add(0, 1, 1, 0, 1, 16'hBEEF, 1, 16'hBEEF, 0, 0, 0);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 16'h1234, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h5555, 0, 16'h5555, 0, 0, 0);
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ce, vecs[i].ld, vecs[i].ds, vecs[i].vi, vecs[i].di);
      chk($sformatf("vec%0d.valid_out", i), 32'(valid_out), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].ed));
      chk($sformatf("vec%0d.depth_q", i), 32'(depth_q), 32'(vecs[i].eq));
      chk($sformatf("vec%0d.in_flight", i), 32'(in_flight), 32'(vecs[i].ef));
      chk($sformatf("vec%0d.cfg_err", i), 32'(cfg_err), 32'(vecs[i].ee));
    end
    // Depth 8 with 5 in flight, then reload to 2 while stalled
    cyc(0, 1, 1, 8, 0, 0);
    chk("t4.depth8", 32'(depth_q), 8);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 1, 16'(16'hA0 + k));
    chk("t4.if5", 32'(in_flight), 5);
    chk("t4.pre_valid", 32'(valid_out), 0);
    cyc(0, 0, 1, 2, 1, 16'h00FF);
    chk("t4.depth2", 32'(depth_q), 2);
    chk("t4.if_flush", 32'(in_flight), 0);
    chk("t4.valid_flush", 32'(valid_out), 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk($sformatf("t4.no_old%0d", k), 32'(valid_out), 0);
      chk($sformatf("t4.if_old%0d", k), 32'(in_flight), 0);
    end
    cyc(0, 1, 0, 0, 1, 16'h0077);
    chk("t4.lat1_valid", 32'(valid_out), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t4.lat2_valid", 32'(valid_out), 1);
    chk("t4.lat2_data", 32'(data_out), 32'h77);
    chk("t4.lat2_if", 32'(in_flight), 1);
    // Over-range request clamps to 16 with a one-cycle error pulse
    cyc(0, 1, 1, 20, 0, 0);
    chk("t5.depth", 32'(depth_q), 16);
    chk("t5.err_hi", 32'(cfg_err), 1);
    cyc(0, 1, 0, 0, 1, 16'h5A5A);
    chk("t5.err_lo", 32'(cfg_err), 0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (valid_out) lat = k;
      else cyc(0, 1, 0, 0, 0, 0);
    end
    chk("t5.latency", 32'(lat), 16);
    chk("t5.data", 32'(data_out), 32'h5A5A);
    // Reset together with cfg_load mid-stream
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1, 16'(16'hC0 + k));
    chk("t6.if_pre", 32'(in_flight), 3);
    cyc(1, 1, 1, 20, 1, 16'hFFFF);
    chk("t6.depth", 32'(depth_q), 4);
    chk("t6.valid", 32'(valid_out), 0);
    chk("t6.if", 32'(in_flight), 0);
    chk("t6.err", 32'(cfg_err), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t6.err_next", 32'(cfg_err), 0);
    chk("t6.valid_next", 32'(valid_out), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
